// File: rtl/arm_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle ARM controller.
// Included by mc_control_fsm and cond_unit.
package arm_ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECR,
        EXECI,
        ALUWB,
        BRANCH
    } state_t;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_8  = 2'b00;
    localparam logic [1:0] IMM_12 = 2'b01;
    localparam logic [1:0] IMM_24 = 2'b10;

    typedef struct packed {
        logic       known;
        logic       wb;
        logic       arith;
        logic       cmp;
        logic [2:0] alu;
    } cmd_dec_t;

    // Unrecognised commands fall back to ADD with no register or flag write.
    function automatic cmd_dec_t decode_cmd(input logic [3:0] cmd);
        cmd_dec_t d;
        d.known = 1'b1;
        d.wb    = 1'b1;
        d.arith = 1'b0;
        d.cmp   = 1'b0;
        d.alu   = ALU_ADD;
        case (cmd)
            CMD_ADD: d.arith = 1'b1;
            CMD_SUB: begin
                d.alu   = ALU_SUB;
                d.arith = 1'b1;
            end
            CMD_CMP: begin
                d.alu   = ALU_SUB;
                d.arith = 1'b1;
                d.cmp   = 1'b1;
                d.wb    = 1'b0;
            end
            CMD_AND: d.alu = ALU_AND;
            CMD_ORR: d.alu = ALU_ORR;
            CMD_EOR: d.alu = ALU_EOR;
            CMD_MOV: d.alu = ALU_MOV;
            default: begin
                d.known = 1'b0;
                d.wb    = 1'b0;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_control_fsm_cond_unit.sv
// NZCV flag register with gated update and ARM condition-code evaluation.
// Condition is always evaluated against the registered flags.
module cond_unit
    import arm_ctrl_pkg::*;
#(
    parameter int NFLAGS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        cond,
    input  logic [NFLAGS-1:0] alu_flags,
    input  logic [1:0]        flag_w,
    output logic              cond_ex,
    output logic [NFLAGS-1:0] flags
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    // flag_w[1] covers N,Z; flag_w[0] covers C,V.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags <= '0;
        end else begin
            if (flag_w[1] && cond_ex) flags[3:2] <= alu_flags[3:2];
            if (flag_w[0] && cond_ex) flags[1:0] <= alu_flags[1:0];
        end
    end

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            COND_EQ: cond_ex = z;
            COND_NE: cond_ex = ~z;
            COND_CS: cond_ex = c;
            COND_CC: cond_ex = ~c;
            COND_MI: cond_ex = n;
            COND_PL: cond_ex = ~n;
            COND_VS: cond_ex = v;
            COND_VC: cond_ex = ~v;
            COND_HI: cond_ex = c & ~z;
            COND_LS: cond_ex = ~c | z;
            COND_GE: cond_ex = (n == v);
            COND_LT: cond_ex = (n != v);
            COND_GT: cond_ex = ~z & (n == v);
            COND_LE: cond_ex = z | (n != v);
            COND_AL: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle ARM main controller: sequences fetch/decode/execute/writeback
// and gates architectural writes on the condition. BL link write: MC_LINK_EN.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <- PC+4
// DECODE | register read, PC+8 presented as R15
// MEMADR | compute load/store address (base +/- imm12)
// MEMRD  | read data memory at ALU result
// MEMWB  | write loaded data to Rd
// MEMWR  | write RD2 to data memory
// EXECR  | data-processing with register operand
// EXECI  | data-processing with imm8 operand
// ALUWB  | write ALU result to Rd
// BRANCH | PC <- PC+8+imm24 (optionally R14 <- PC+4)
module mc_control_fsm
    import arm_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3,
    parameter int NFLAGS    = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           Cond,
    input  logic [1:0]           Op,
    input  logic [5:0]           Funct,
    input  logic [3:0]           Rd,
    input  logic [NFLAGS-1:0]    ALUFlags,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic                 ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 LSrc
);

    state_t            state, state_nxt;
    cmd_dec_t          dec;
    logic              cond_ex;
    logic [NFLAGS-1:0] flags;
    logic              ir_w, reg_w, mem_w, branch, link, is_fetch;
    logic [1:0]        flag_w;
    logic [2:0]        alu_sel;

    assign dec = decode_cmd(Funct[4:1]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ir_w      = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        ImmSrc    = IMM_8;
        alu_sel   = ALU_ADD;
        reg_w     = 1'b0;
        mem_w     = 1'b0;
        branch    = 1'b0;
        link      = 1'b0;
        is_fetch  = 1'b0;
        flag_w    = 2'b00;
        case (state)
            FETCH: begin
                ir_w      = 1'b1;
                is_fetch  = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                state_nxt = DECODE;
            end
            DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURES;
                case (Op)
                    OP_MEM:  state_nxt = MEMADR;
                    OP_DP:   state_nxt = Funct[5] ? EXECI : EXECR;
                    OP_BR:   state_nxt = BRANCH;
                    default: state_nxt = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_12;
                alu_sel   = Funct[3] ? ALU_ADD : ALU_SUB;
                state_nxt = Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc    = 1'b1;
                state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                state_nxt = FETCH;
            end
            MEMWR: begin
                AdrSrc    = 1'b1;
                mem_w     = 1'b1;
                state_nxt = FETCH;
            end
            EXECR, EXECI: begin
                ALUSrcB   = (state == EXECI) ? SRCB_IMM : SRCB_REG;
                ImmSrc    = IMM_8;
                alu_sel   = dec.alu;
                // CMP always sets NZCV; S on a known command sets NZ, plus CV for arithmetic.
                if (dec.cmp)
                    flag_w = 2'b11;
                else if (Funct[0] && dec.known)
                    flag_w = {1'b1, dec.arith};
                state_nxt = dec.cmp ? FETCH : ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = dec.wb;
                state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA   = 1'b0;
                ALUSrcB   = SRCB_IMM;
                ImmSrc    = IMM_24;
                ResultSrc = RES_ALURES;
                branch    = 1'b1;
`ifdef MC_LINK_EN
                link      = Funct[4];
                reg_w     = Funct[4];
`endif
                state_nxt = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    cond_unit #(
        .NFLAGS (NFLAGS)
    ) u_cond (
        .clk       (clk),
        .rst_n     (reset),
        .cond      (Cond),
        .alu_flags (ALUFlags),
        .flag_w    (flag_w),
        .cond_ex   (cond_ex),
        .flags     (flags)
    );

    // Enables are masked by reset so nothing writes while it is held low.
    assign IRWrite    = reset & ir_w;
    assign RegWrite   = reset & reg_w & cond_ex;
    assign MemWrite   = reset & mem_w & cond_ex;
    assign PCWrite    = reset & (is_fetch | (branch & cond_ex) |
                                 (reg_w & cond_ex & (Rd == 4'hF)));
    assign LSrc       = link & cond_ex;
    assign RegSrc     = {Op == OP_MEM, Op == OP_BR};
    assign ALUControl = alu_sel;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm; per-instruction traces checked against
// hand-derived cycle patterns. Honours MC_LINK_EN for the BL case.
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] Cond;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] ALUFlags;
    logic       PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA, LSrc;
    logic [1:0] RegSrc, ALUSrcB, ResultSrc, ImmSrc;
    logic [2:0] ALUControl;

    int n_tests = 0;
    int n_fail  = 0;
    int ncyc;

    logic [7:0] rw_h, mw_h, pw_h, adr_h, ls_h, asa_h;
    logic [2:0] alu_h [8];
    logic [1:0] rs_h  [8];
    logic [1:0] sb_h  [8];
    logic [1:0] imm_h [8];
    logic [1:0] rsg_h [8];

    mc_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Cond       (Cond),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .IRWrite    (IRWrite),
        .AdrSrc     (AdrSrc),
        .RegSrc     (RegSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ImmSrc     (ImmSrc),
        .ALUControl (ALUControl),
        .LSrc       (LSrc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // Presents one instruction from FETCH and traces outputs until the next FETCH.
    task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] fl);
        Cond = c; Op = o; Funct = f; Rd = r; ALUFlags = fl;
        #1;
        ncyc = 0;
        rw_h = '0; mw_h = '0; pw_h = '0; adr_h = '0; ls_h = '0; asa_h = '0;
        for (int i = 0; i < 8; i++) begin
            alu_h[i] = '0; rs_h[i] = '0; sb_h[i] = '0; imm_h[i] = '0; rsg_h[i] = '0;
        end
        do begin
            rw_h[ncyc]  = RegWrite;
            mw_h[ncyc]  = MemWrite;
            pw_h[ncyc]  = PCWrite;
            adr_h[ncyc] = AdrSrc;
            ls_h[ncyc]  = LSrc;
            asa_h[ncyc] = ALUSrcA;
            alu_h[ncyc] = ALUControl;
            rs_h[ncyc]  = ResultSrc;
            sb_h[ncyc]  = ALUSrcB;
            imm_h[ncyc] = ImmSrc;
            rsg_h[ncyc] = RegSrc;
            @(posedge clk); #2;
            ncyc++;
        end while (IRWrite !== 1'b1 && ncyc < 8);
    endtask

    task automatic resync();
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; Cond = 4'hE; Op = 2'b00; Funct = 6'b0; Rd = 4'h0; ALUFlags = 4'h0;
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_enables: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if ({PCWrite, IRWrite, ALUSrcA, ALUSrcB} !== 5'b11110) begin
            n_fail++;
            $display("FAIL reset_fetch: got %b expected 11110", {PCWrite, IRWrite, ALUSrcA, ALUSrcB});
        end
        @(posedge clk); #2;
        n_tests++;
        if (IRWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_decode_irwrite: got %b expected 0", IRWrite);
        end
        resync();
    endtask

    task automatic test_add_imm();
        run_instr(4'hE, 2'b00, 6'b101000, 4'h1, 4'h0);
        n_tests++;
        if (ncyc !== 4) begin n_fail++; $display("FAIL add_latency: got %0d expected 4", ncyc); end
        n_tests++;
        if (rw_h !== 8'b00001000) begin n_fail++; $display("FAIL add_regwrite: got %b expected 00001000", rw_h); end
        n_tests++;
        if ({alu_h[2], sb_h[2], imm_h[2]} !== 7'b0000100) begin
            n_fail++;
            $display("FAIL add_exec_ctl: got %b expected 0000100", {alu_h[2], sb_h[2], imm_h[2]});
        end
        n_tests++;
        if (pw_h !== 8'b00000001) begin n_fail++; $display("FAIL add_pcwrite: got %b expected 00000001", pw_h); end
    endtask

    task automatic test_subs_addeq();
        run_instr(4'hE, 2'b00, 6'b000101, 4'h0, 4'b0100);
        n_tests++;
        if ({ncyc[3:0], alu_h[2], sb_h[2]} !== {4'd4, 3'b001, 2'b00}) begin
            n_fail++;
            $display("FAIL subs_exec: got %0d/%b/%b expected 4/001/00", ncyc, alu_h[2], sb_h[2]);
        end
        run_instr(4'h0, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b00001000) begin n_fail++; $display("FAIL addeq_z1: got %b expected 00001000", rw_h); end
        run_instr(4'hE, 2'b00, 6'b000101, 4'h0, 4'b0000);
        run_instr(4'h0, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b0) begin n_fail++; $display("FAIL addeq_z0_regwrite: got %b expected 00000000", rw_h); end
        n_tests++;
        if (ncyc !== 4) begin n_fail++; $display("FAIL addeq_z0_latency: got %0d expected 4", ncyc); end
    endtask

    task automatic test_flags();
        run_instr(4'hE, 2'b00, 6'b010101, 4'h0, 4'b0100);
        n_tests++;
        if (ncyc !== 3 || rw_h !== 8'b0 || alu_h[2] !== 3'b001) begin
            n_fail++;
            $display("FAIL cmp: got lat %0d rw %b alu %b expected 3/00000000/001", ncyc, rw_h, alu_h[2]);
        end
        // unknown cmd with S: no write, no flag change
        run_instr(4'hE, 2'b00, 6'b000111, 4'h3, 4'b0000);
        n_tests++;
        if (ncyc !== 4 || rw_h !== 8'b0 || alu_h[2] !== 3'b000) begin
            n_fail++;
            $display("FAIL unknown_cmd: got lat %0d rw %b alu %b expected 4/00000000/000", ncyc, rw_h, alu_h[2]);
        end
        // CMPNE fails with Z=1, so flags stay
        run_instr(4'h1, 2'b00, 6'b010101, 4'h0, 4'b0000);
        run_instr(4'h0, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b00001000) begin n_fail++; $display("FAIL flags_kept_addeq: got %b expected 00001000", rw_h); end
        // MOVS writes N,Z only; C stays 0
        run_instr(4'hE, 2'b00, 6'b011011, 4'h4, 4'b0011);
        n_tests++;
        if (alu_h[2] !== 3'b101) begin n_fail++; $display("FAIL movs_alu: got %b expected 101", alu_h[2]); end
        run_instr(4'h2, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b0) begin n_fail++; $display("FAIL movs_no_c_addcs: got %b expected 00000000", rw_h); end
        run_instr(4'hE, 2'b00, 6'b001001, 4'h5, 4'b0010);
        run_instr(4'h2, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b00001000) begin n_fail++; $display("FAIL adds_c_addcs: got %b expected 00001000", rw_h); end
    endtask

    task automatic test_pc_dest();
        run_instr(4'hE, 2'b00, 6'b001000, 4'hF, 4'h0);
        n_tests++;
        if (pw_h !== 8'b00001001) begin n_fail++; $display("FAIL add_pc_dest: got %b expected 00001001", pw_h); end
        run_instr(4'hE, 2'b00, 6'b010101, 4'hF, 4'h0);
        n_tests++;
        if (pw_h !== 8'b00000001) begin n_fail++; $display("FAIL cmp_rd15_no_pc: got %b expected 00000001", pw_h); end
    endtask

    task automatic test_ldr();
        run_instr(4'hE, 2'b01, 6'b011001, 4'h3, 4'h0);
        n_tests++;
        if (ncyc !== 5) begin n_fail++; $display("FAIL ldr_latency: got %0d expected 5", ncyc); end
        n_tests++;
        if (adr_h !== 8'b00001000) begin n_fail++; $display("FAIL ldr_adrsrc: got %b expected 00001000", adr_h); end
        n_tests++;
        if (rw_h !== 8'b00010000 || rs_h[4] !== 2'b01) begin
            n_fail++;
            $display("FAIL ldr_writeback: got rw %b rsrc %b expected 00010000/01", rw_h, rs_h[4]);
        end
        n_tests++;
        if ({alu_h[2], sb_h[2], imm_h[2]} !== 7'b0000101) begin
            n_fail++;
            $display("FAIL ldr_memadr: got %b expected 0000101", {alu_h[2], sb_h[2], imm_h[2]});
        end
    endtask

    task automatic test_str();
        run_instr(4'hE, 2'b00, 6'b000101, 4'h0, 4'b0100);
        run_instr(4'h1, 2'b01, 6'b011000, 4'h3, 4'h0);
        n_tests++;
        if (ncyc !== 4 || mw_h !== 8'b0) begin
            n_fail++;
            $display("FAIL strne_z1: got lat %0d mw %b expected 4/00000000", ncyc, mw_h);
        end
        run_instr(4'hE, 2'b01, 6'b010000, 4'h3, 4'h0);
        n_tests++;
        if (mw_h !== 8'b00001000 || adr_h !== 8'b00001000 || rw_h !== 8'b0) begin
            n_fail++;
            $display("FAIL str_al: got mw %b adr %b rw %b expected 00001000/00001000/00000000", mw_h, adr_h, rw_h);
        end
        n_tests++;
        if (alu_h[2] !== 3'b001 || rsg_h[1] !== 2'b10) begin
            n_fail++;
            $display("FAIL str_sub_regsrc: got alu %b regsrc %b expected 001/10", alu_h[2], rsg_h[1]);
        end
    endtask

    task automatic test_branch();
        run_instr(4'hE, 2'b10, 6'b100000, 4'h0, 4'h0);
        n_tests++;
        if (ncyc !== 3 || pw_h !== 8'b00000101) begin
            n_fail++;
            $display("FAIL b_al: got lat %0d pw %b expected 3/00000101", ncyc, pw_h);
        end
        n_tests++;
        if ({asa_h[2], sb_h[2], imm_h[2], rs_h[2], rsg_h[2]} !== 9'b0_01_10_10_01) begin
            n_fail++;
            $display("FAIL b_ctl: got %b expected 001101001", {asa_h[2], sb_h[2], imm_h[2], rs_h[2], rsg_h[2]});
        end
        run_instr(4'hF, 2'b10, 6'b100000, 4'h0, 4'h0);
        n_tests++;
        if (ncyc !== 3 || pw_h !== 8'b00000001) begin
            n_fail++;
            $display("FAIL b_nv: got lat %0d pw %b expected 3/00000001", ncyc, pw_h);
        end
        run_instr(4'hE, 2'b10, 6'b110000, 4'h0, 4'h0);
`ifdef MC_LINK_EN
        n_tests++;
        if (ls_h !== 8'b00000100 || rw_h !== 8'b00000100 || pw_h !== 8'b00000101 || ncyc !== 3) begin
            n_fail++;
            $display("FAIL bl_link: got ls %b rw %b pw %b lat %0d expected 00000100/00000100/00000101/3", ls_h, rw_h, pw_h, ncyc);
        end
`else
        n_tests++;
        if (ls_h !== 8'b0 || rw_h !== 8'b0 || pw_h !== 8'b00000101 || ncyc !== 3) begin
            n_fail++;
            $display("FAIL bl_as_b: got ls %b rw %b pw %b lat %0d expected 00000000/00000000/00000101/3", ls_h, rw_h, pw_h, ncyc);
        end
`endif
    endtask

    task automatic test_undef_op();
        run_instr(4'hE, 2'b11, 6'b001000, 4'hF, 4'h0);
        n_tests++;
        if (ncyc !== 2 || rw_h !== 8'b0 || pw_h !== 8'b00000001) begin
            n_fail++;
            $display("FAIL undef_op: got lat %0d rw %b pw %b expected 2/00000000/00000001", ncyc, rw_h, pw_h);
        end
    endtask

    task automatic test_reset_mid_memrd();
        run_instr(4'hE, 2'b00, 6'b000101, 4'h0, 4'b0100);
        Cond = 4'hE; Op = 2'b01; Funct = 6'b011001; Rd = 4'h3; ALUFlags = 4'h0;
        repeat (3) begin
            @(posedge clk); #2;
        end
        n_tests++;
        if (AdrSrc !== 1'b1) begin n_fail++; $display("FAIL memrd_reached: got AdrSrc %b expected 1", AdrSrc); end
        reset = 1'b0;
        #1;
        n_tests++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc} !== 5'b00000) begin
            n_fail++;
            $display("FAIL mid_reset_enables: got %b expected 00000", {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc});
        end
        repeat (2) @(posedge clk);
        #2;
        n_tests++;
        if ({PCWrite, MemWrite, RegWrite, IRWrite} !== 4'b0000) begin
            n_fail++;
            $display("FAIL mid_reset_held: got %b expected 0000", {PCWrite, MemWrite, RegWrite, IRWrite});
        end
        reset = 1'b1;
        #1;
        n_tests++;
        if (IRWrite !== 1'b1) begin n_fail++; $display("FAIL mid_reset_release: got IRWrite %b expected 1", IRWrite); end
        @(posedge clk); #2;
        n_tests++;
        if (IRWrite !== 1'b0) begin n_fail++; $display("FAIL mid_reset_decode: got IRWrite %b expected 0", IRWrite); end
        resync();
        // flags cleared by reset: ADDEQ must not write
        run_instr(4'h0, 2'b00, 6'b001000, 4'h2, 4'h0);
        n_tests++;
        if (rw_h !== 8'b0) begin n_fail++; $display("FAIL flags_cleared_addeq: got %b expected 00000000", rw_h); end
    endtask

    initial begin
        test_reset();
        test_add_imm();
        test_subs_addeq();
        test_flags();
        test_pc_dest();
        test_ldr();
        test_str();
        test_branch();
        test_undef_op();
        test_reset_mid_memrd();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
